dma_mem_cpu_oci_dct_ctrl: RTL
=============================

# dma_mem_cpu_oci_dct_ctrl

Sequencer for the Nios II OCI debug-capture-trace (DCT) path of the DMA memory CPU. It packs 10-bit trace records into 30-bit DCT buffers, presents each buffer with its record count to a downstream sink over a valid/ready handshake, and counts records dropped under backpressure. On `test_ending` it flushes any partial buffer and raises `test_has_ended` once everything has drained.

## Interface
- `REC_W`, 10: trace record width.
- `RECS`, 3: records per DCT buffer. Buffer width is `REC_W*RECS` = 30.
- `CNT_W`, 4: width of the `dct_count` field.
- `DROP_W`, 8: width of the drop counter.
- Clock and reset: one clock, `clk`; reset `reset_n` is asynchronous and active-low.
- `clk`  in  1  sole clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `rec_valid`  in  1  trace record strobe. There is no ready; the CPU is never stalled.
- `rec_data`  in  10  trace record.
- `test_ending`  in  1  flush request, level-sampled.
- `out_ready`  in  1  sink accepts the buffer.
- `out_valid`  out  1  `dct_buffer`/`dct_count` are valid.
- `dct_buffer`  out  30  packed records; slot i occupies bits [10i+9:10i].
- `dct_count`  out  4  records held in `dct_buffer` (1..3 when valid).
- `test_has_ended`  out  1  flush complete; sticky until reset.
- `drop_count`  out  8  saturating count of dropped records.

## Operation
- Two registers:
  - Fill register: 30-bit data plus count `fcnt` (0..3).
  - Output register: drives `dct_buffer`, `dct_count` and `out_valid`.
- The output slot is "free" when `out_valid`=0, or when `out_valid`=1 and `out_ready`=1 in the same cycle.
- States: CAPTURE (reset state), FLUSH, ENDED.
- CAPTURE, record accepted while `fcnt`<3:
  - Write `rec_data` into slot `fcnt`.
  - If this is the third record and the output slot is free, load the output register with the full buffer and count 3, and set `fcnt` to 0.
  - Otherwise increment `fcnt`.
- `fcnt`=3 with the output slot free: transfer the fill register to the output register and set `fcnt` to 0.
- Record arriving while `fcnt`=3 and no transfer this cycle: the record is dropped and `drop_count` increments, saturating at 255.
- `test_ending`=1 in CAPTURE: go to FLUSH. A record arriving in the same cycle is still captured.
- FLUSH:
  - `rec_valid` is ignored; nothing is captured and nothing is counted as dropped.
  - If `fcnt`>0 and the output slot is free, transfer the partial buffer with count `fcnt`. Unused slots read 0.
  - When `fcnt`=0 and `out_valid`=0, go to ENDED.
- ENDED:
  - `test_has_ended`=1.
  - All inputs except `reset_n` are ignored.
  - Only reset leaves this state.
- Handshake: while `out_valid`=1 and `out_ready`=0, `dct_buffer` and `dct_count` hold stable.
- Unused slots of a transferred buffer are zero; the fill register clears on each transfer.

## Timing
- Reset values: `out_valid`=0, `dct_buffer`=0, `dct_count`=0, `test_has_ended`=0, `drop_count`=0, `fcnt`=0, state CAPTURE.
- Reset asserted mid-operation clears everything immediately. Buffered records are discarded, not flushed.
- Latency:
  - Third record sampled at edge N with the slot free: `out_valid`=1 from edge N.
  - Blocked full buffer: moves to the output register at the first edge where the slot is free.
- Back-to-back streaming: a 3-record buffer can be replaced in the same edge it is consumed. Sustained full rate produces zero drops while `out_ready`=1.
- `test_has_ended` rises at the edge after the last buffer is consumed (ENDED is entered at that edge).
- `drop_count` holds at 255; it never wraps.

## Structure
- Shared package `dma_mem_cpu_oci_dct_pkg` holds:
  - constants `REC_W`, `RECS`, `CNT_W`, `DROP_W`;
  - the state enum {CAPTURE, FLUSH, ENDED}.
- No sub-module is required. The saturating drop counter is inline logic.
- `dma_mem_cpu_cpu_oci_test_bench` is the consumer of `dct_buffer`, `dct_count`, `test_ending` and `test_has_ended` in simulation.

## Test plan
- Records 0x001, 0x002, 0x003 with `out_ready`=1 → one buffer, `dct_buffer`=0x00300801, `dct_count`=3, `drop_count`=0.
- Continuous records with `out_ready`=0 → after 3 records `out_valid`=1 and the output holds stable. The next 3 records fill the fill register. Records 7..10 are dropped, so `drop_count`=4.
- 2 records, then `test_ending` → `dct_buffer`=(r1<<10)|r0, `dct_count`=2, upper slot 0. `test_has_ended`=1 one edge after acceptance.
- `test_ending` asserted with a record in the same cycle, fill empty → that record is flushed with `dct_count`=1. Later records are ignored and `drop_count` is unchanged.
- 300 dropped records → `drop_count`=255. `reset_n` pulsed mid-buffer → all outputs return to 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/dma_mem_cpu_oci_dct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_mem_cpu_oci_dct_pkg
// Brief    : Shared constants, state encoding and slot helper for the DCT path
// Revision : 1.0
// ============================================================================
package dma_mem_cpu_oci_dct_pkg;

    localparam int REC_W  = 10;
    localparam int RECS   = 3;
    localparam int CNT_W  = 4;
    localparam int DROP_W = 8;
    localparam int BUF_W  = REC_W * RECS;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RECS);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        FLUSH   = 2'd1,
        ENDED   = 2'd2
    } dct_state_t;

    // Returns a buffer holding rec in the given slot and zero elsewhere.
    function automatic logic [BUF_W-1:0] place_rec(input logic [REC_W-1:0] rec,
                                                   input logic [CNT_W-1:0] slot);
        logic [BUF_W-1:0] res;
        res = '0;
        for (int i = 0; i < RECS; i++) begin
            if (slot == CNT_W'(i)) begin
                res[i*REC_W +: REC_W] = rec;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_mem_cpu_oci_dct_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_mem_cpu_oci_dct_ctrl_if
// Brief    : DCT buffer stream (valid/ready) between the sequencer and its sink
// Revision : 1.0
// ============================================================================
interface dma_mem_cpu_oci_dct_ctrl_if;
    import dma_mem_cpu_oci_dct_pkg::*;

    logic             out_valid;
    logic             out_ready;
    logic [BUF_W-1:0] dct_buffer;
    logic [CNT_W-1:0] dct_count;

    modport master (
        output out_valid,
        output dct_buffer,
        output dct_count,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  dct_buffer,
        input  dct_count,
        output out_ready
    );

endinterface
`default_nettype wire

// File: rtl/dma_mem_cpu_oci_dct_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dma_mem_cpu_oci_dct_ctrl
// Brief    : Packs trace records into DCT buffers, flushes on test end
// Revision : 1.0
// ============================================================================
module dma_mem_cpu_oci_dct_ctrl
    import dma_mem_cpu_oci_dct_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic              rec_valid,
    input  wire logic [REC_W-1:0]  rec_data,
    input  wire logic              test_ending,
    dma_mem_cpu_oci_dct_ctrl_if.master dct,
    output logic                   test_has_ended,
    output logic [DROP_W-1:0]      drop_count
);

    dct_state_t        r_state,     w_state;
    logic [BUF_W-1:0]  r_fill,      w_fill;
    logic [CNT_W-1:0]  r_fcnt,      w_fcnt;
    logic              r_out_valid, w_out_valid;
    logic [BUF_W-1:0]  r_out_buf,   w_out_buf;
    logic [CNT_W-1:0]  r_out_cnt,   w_out_cnt;
    logic [DROP_W-1:0] r_drop,      w_drop;
    logic              w_slot_free;

    assign w_slot_free = !r_out_valid || dct.out_ready;

    always_comb begin
        w_state     = r_state;
        w_fill      = r_fill;
        w_fcnt      = r_fcnt;
        w_out_valid = r_out_valid;
        w_out_buf   = r_out_buf;
        w_out_cnt   = r_out_cnt;
        w_drop      = r_drop;

        // A consumed buffer frees the slot; a load below may refill it at once.
        if (r_out_valid && dct.out_ready) begin
            w_out_valid = 1'b0;
        end

        case (r_state)
            CAPTURE: begin
                if (r_fcnt == FULL_CNT) begin
                    if (w_slot_free) begin
                        w_out_valid = 1'b1;
                        w_out_buf   = r_fill;
                        w_out_cnt   = FULL_CNT;
                        w_fill      = '0;
                        w_fcnt      = '0;
                        if (rec_valid) begin
                            w_fill = place_rec(rec_data, '0);
                            w_fcnt = CNT_W'(1);
                        end
                    end else if (rec_valid && (r_drop != '1)) begin
                        w_drop = r_drop + 1'b1;
                    end
                end else if (rec_valid) begin
                    if ((r_fcnt == FULL_CNT - 1'b1) && w_slot_free) begin
                        w_out_valid = 1'b1;
                        w_out_buf   = r_fill | place_rec(rec_data, r_fcnt);
                        w_out_cnt   = FULL_CNT;
                        w_fill      = '0;
                        w_fcnt      = '0;
                    end else begin
                        w_fill = r_fill | place_rec(rec_data, r_fcnt);
                        w_fcnt = r_fcnt + 1'b1;
                    end
                end
                if (test_ending) begin
                    w_state = FLUSH;
                end
            end

            FLUSH: begin
                if ((r_fcnt != '0) && w_slot_free) begin
                    w_out_valid = 1'b1;
                    w_out_buf   = r_fill;
                    w_out_cnt   = r_fcnt;
                    w_fill      = '0;
                    w_fcnt      = '0;
                end else if ((r_fcnt == '0) && !r_out_valid) begin
                    w_state = ENDED;
                end
            end

            ENDED: begin
                w_state = ENDED;
            end

            default: begin
                w_state = CAPTURE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= CAPTURE;
            r_fill      <= '0;
            r_fcnt      <= '0;
            r_out_valid <= 1'b0;
            r_out_buf   <= '0;
            r_out_cnt   <= '0;
            r_drop      <= '0;
        end else begin
            r_state     <= w_state;
            r_fill      <= w_fill;
            r_fcnt      <= w_fcnt;
            r_out_valid <= w_out_valid;
            r_out_buf   <= w_out_buf;
            r_out_cnt   <= w_out_cnt;
            r_drop      <= w_drop;
        end
    end

    assign dct.out_valid  = r_out_valid;
    assign dct.dct_buffer = r_out_buf;
    assign dct.dct_count  = r_out_cnt;
    assign test_has_ended = (r_state == ENDED);
    assign drop_count     = r_drop;

endmodule
`default_nettype wire
